// File: rtl/coeff_bram_sched.sv
// coeff_bram_sched: owns the single coefficient BRAM port, sharing it between host access and per-frame reload.
// Latency: host write 0 cycles, host read RD_LAT cycles; reload runs NUM_COEFF+RD_LAT+1 cycles from vs fall to load_done.
// Backpressure: host_gnt stays 0 while a reload is requested, pending, running, or completing (load_done cycle).
//
// Optional feature: define COEFF_SCHED_OVERRUN_CNT_EN to build the saturating missed-reload counter;
// without it overrun_cnt is tied to 0 (the port is always present).
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   vs_i                           vertical sync, falling edge requests a reload
//   host_req/we/addr/wdata         host access request (held until host_gnt)
//   host_gnt                       combinational grant, access executes this cycle
//   host_rvalid/host_rdata         read data pulse, RD_LAT cycles after grant
//   bram_en/we/addr/wdata/rdata    single BRAM port
//   coeff_we/idx/val               register-file write strobes during reload
//   busy, load_done, overrun_cnt   reload status
module coeff_bram_sched #(
  parameter int NUM_COEFF = 25,
  parameter int ADDR_W    = 6,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vs_i,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [15:0]       host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [15:0]       host_rdata,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
  input  logic [31:0]       bram_rdata,
  output logic              coeff_we,
  output logic [4:0]        coeff_idx,
  output logic [15:0]       coeff_val,
  output logic              busy,
  output logic              load_done,
  output logic [7:0]        overrun_cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HOST_RD = 2'd1;
  localparam logic [1:0] S_LOAD    = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  localparam logic [1:0]        LAT_LAST = 2'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(NUM_COEFF - 1);

  logic [1:0]        state, state_nxt;
  logic              vs_q;
  logic              vs_edge;
  logic              load_pend, pend_nxt;
  logic [ADDR_W-1:0] rd_cnt, rd_cnt_nxt;
  logic [1:0]        wait_cnt, wait_nxt;
  logic              wait_last;
  logic              load_req;
  logic              load_issue;
  logic              load_done_q;

  // Return-path delay line: stage RD_LAT-1 lines up with bram_rdata.
  logic [RD_LAT-1:0] dl_vld;
  logic [4:0]        dl_idx [RD_LAT];

  // Upper BRAM data bits are not used by this block.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^bram_rdata[31:16];

  assign vs_edge    = vs_q & ~vs_i;
  assign wait_last  = (wait_cnt == LAT_LAST);
  assign load_req   = vs_edge | load_pend;
  assign load_issue = (state == S_LOAD);
  assign busy       = (state == S_LOAD) || (state == S_DRAIN);

  // Reload beats host in IDLE; the load_done cycle is also kept free of host
  // traffic so the register file update completes before the host resumes.
  // rst_n gates the combinational grant so outputs read 0 while in reset.
  assign host_gnt = rst_n && (state == S_IDLE) && !load_req && !load_done_q && host_req;

  assign bram_en    = load_issue | host_gnt;
  assign bram_we    = host_gnt & host_we;
  assign bram_addr  = load_issue ? rd_cnt : (host_gnt ? host_addr : '0);
  assign bram_wdata = bram_we ? {16'h0000, host_wdata} : 32'h0;

  assign host_rvalid = (state == S_HOST_RD) && wait_last;
  assign host_rdata  = host_rvalid ? bram_rdata[15:0] : 16'h0000;

  assign coeff_we  = dl_vld[RD_LAT-1];
  assign coeff_idx = coeff_we ? dl_idx[RD_LAT-1] : 5'd0;
  assign coeff_val = coeff_we ? bram_rdata[15:0] : 16'h0000;

  assign load_done = load_done_q;

  always_comb begin
    state_nxt  = state;
    rd_cnt_nxt = rd_cnt;
    wait_nxt   = wait_cnt;
    pend_nxt   = load_pend;
    case (state)
      S_IDLE: begin
        if (load_req) begin
          state_nxt  = S_LOAD;
          rd_cnt_nxt = '0;
          pend_nxt   = 1'b0;
        end else if (host_gnt && !host_we) begin
          state_nxt = S_HOST_RD;
          wait_nxt  = 2'd0;
        end
      end
      S_HOST_RD: begin
        if (wait_last) begin
          // A reload deferred by this read starts right after host_rvalid.
          if (load_req) begin
            state_nxt  = S_LOAD;
            rd_cnt_nxt = '0;
            pend_nxt   = 1'b0;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          wait_nxt = wait_cnt + 2'd1;
          if (vs_edge) begin
            pend_nxt = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (rd_cnt == CNT_LAST) begin
          state_nxt = S_DRAIN;
          wait_nxt  = 2'd0;
        end else begin
          rd_cnt_nxt = rd_cnt + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (wait_last) begin
          state_nxt = S_IDLE;
        end else begin
          wait_nxt = wait_cnt + 2'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      vs_q        <= 1'b0;
      load_pend   <= 1'b0;
      rd_cnt      <= '0;
      wait_cnt    <= 2'd0;
      load_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      vs_q        <= vs_i;
      load_pend   <= pend_nxt;
      rd_cnt      <= rd_cnt_nxt;
      wait_cnt    <= wait_nxt;
      load_done_q <= (state == S_DRAIN) && wait_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dl_idx[i] <= 5'd0;
      end
    end else begin
      dl_vld[0] <= load_issue;
      dl_idx[0] <= 5'(rd_cnt);
      for (int i = 1; i < RD_LAT; i++) begin
        dl_vld[i] <= dl_vld[i-1];
        dl_idx[i] <= dl_idx[i-1];
      end
    end
  end

`ifdef COEFF_SCHED_OVERRUN_CNT_EN
  // A vs fall while a reload is still running is a missed frame; saturates at 255.
  logic [7:0] ovr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q <= 8'd0;
    end else if (vs_edge && busy && (ovr_q != 8'hFF)) begin
      ovr_q <= ovr_q + 8'd1;
    end
  end

  assign overrun_cnt = ovr_q;
`else
  assign overrun_cnt = 8'd0;
`endif

endmodule
